// File: rtl/sample_dma.sv
// Sample DMA: pops 16-bit samples from a standard-mode FIFO and writes them to a
// circular or one-shot SDRAM window [BASE, LIMIT) through a request/grant write port.
module sample_dma #(
  parameter int AW = 24
) (
  input  logic          clk_48,
  input  logic          irst,
  input  logic          fifo_empty,
  input  logic [15:0]   fifo_rd_data,
  output logic          fifo_rd,
  output logic          dma_req,
  input  logic          dma_gnt,
  output logic [AW-1:0] awaddr,
  output logic [15:0]   wdata,
  output logic          wvalid,
  input  logic          wready,
  input  logic [2:0]    reg_addr,
  input  logic [31:0]   reg_wdata,
  input  logic          reg_wvalid,
  output logic [31:0]   reg_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_REQ,
    ST_WRITE,
    ST_STOP
  } state_t;

  state_t state_q, state_d;

  logic          en_q, en_d;
  logic          wrap_q, wrap_d;
  logic          full_q, full_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] limit_q, limit_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [31:0]   count_q, count_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [15:0]   wdata_q, wdata_d;

  logic          wr_ctrl, wr_base, wr_limit, wr_wptr, wr_count;
  logic          en_rise, clear_full, handshake, at_limit, can_pop, busy;
  logic [AW-1:0] wptr_inc;

  assign wr_ctrl    = reg_wvalid && (reg_addr == 3'd0);
  assign wr_base    = reg_wvalid && (reg_addr == 3'd1);
  assign wr_limit   = reg_wvalid && (reg_addr == 3'd2);
  assign wr_wptr    = reg_wvalid && (reg_addr == 3'd3);
  assign wr_count   = reg_wvalid && (reg_addr == 3'd4);
  assign en_rise    = wr_ctrl && reg_wdata[0] && !en_q;
  assign clear_full = wr_ctrl && reg_wdata[2];

  assign handshake  = (state_q == ST_WRITE) && wready;
  assign wptr_inc   = awaddr_q + AW'(1);
  assign at_limit   = (wptr_inc == limit_q);

  // Register file next-state; a handshake is applied last so it wins over CPU writes.
  always_comb begin
    en_d    = en_q;
    wrap_d  = wrap_q;
    base_d  = base_q;
    limit_d = limit_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    full_d  = full_q;

    if (wr_ctrl) begin
      en_d   = reg_wdata[0];
      wrap_d = reg_wdata[1];
    end
    if (wr_base && !en_q) begin
      base_d = reg_wdata[AW-1:0];
    end
    if (wr_limit && !en_q) begin
      limit_d = reg_wdata[AW-1:0];
    end
    if (wr_wptr && !en_q) begin
      wptr_d = reg_wdata[AW-1:0];
    end
    if (wr_count) begin
      count_d = reg_wdata;
    end

    // An enabled pointer sitting on LIMIT re-asserts full even after software clears it.
    if (en_q && (wptr_q == limit_q)) begin
      full_d = 1'b1;
    end
    if (clear_full) begin
      full_d = 1'b0;
    end
    if (en_rise) begin
      wptr_d  = base_q;
      count_d = '0;
      full_d  = (base_q == limit_q);
    end

    if (handshake) begin
      count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
      if (at_limit && wrap_q) begin
        wptr_d = base_q;
      end else begin
        wptr_d = wptr_inc;
      end
      if (at_limit && !wrap_q) begin
        full_d = 1'b1;
      end
    end
  end

  // Pop decision looks at post-write values so a same-cycle disable or clear cannot leak a pop.
  assign can_pop = en_d && !full_d && !fifo_empty && (wptr_d != limit_q);

  // LATCH already drives dma_req, so a grant seen there skips REQ for 4-cycle throughput.
  always_comb begin
    state_d  = state_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (can_pop) begin
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        wdata_d  = fifo_rd_data;
        awaddr_d = wptr_q;
        state_d  = dma_gnt ? ST_WRITE : ST_REQ;
      end
      ST_REQ: begin
        awaddr_d = wptr_q;
        if (dma_gnt) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wready) begin
          state_d = (at_limit && !wrap_q) ? ST_STOP : ST_IDLE;
        end
      end
      ST_STOP: begin
        if (clear_full || en_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_48 or posedge irst) begin
    if (irst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      wrap_q   <= 1'b0;
      full_q   <= 1'b0;
      base_q   <= '0;
      limit_q  <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      wrap_q   <= wrap_d;
      full_q   <= full_d;
      base_q   <= base_d;
      limit_q  <= limit_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_STOP);
  assign fifo_rd = (state_q == ST_POP);
  assign dma_req = (state_q == ST_LATCH) || (state_q == ST_REQ) || (state_q == ST_WRITE);
  assign wvalid  = (state_q == ST_WRITE);
  assign awaddr  = awaddr_q;
  assign wdata   = wdata_q;

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0:    reg_rdata = {28'b0, busy, full_q, wrap_q, en_q};
      3'd1:    reg_rdata = 32'(base_q);
      3'd2:    reg_rdata = 32'(limit_q);
      3'd3:    reg_rdata = 32'(wptr_q);
      3'd4:    reg_rdata = count_q;
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sample_dma.sv
// Bench for sample_dma: FIFO and SDRAM port models, window/wrap reference model,
// directed corner cases and randomized handshake runs.
module tb_sample_dma;
  localparam int AW = 24;

  logic          clk_48 = 1'b0;
  logic          irst = 1'b1;
  logic          fifo_empty;
  logic [15:0]   fifo_rd_data = 16'h0;
  logic          fifo_rd;
  logic          dma_req;
  logic          dma_gnt = 1'b0;
  logic [AW-1:0] awaddr;
  logic [15:0]   wdata;
  logic          wvalid;
  logic          wready = 1'b0;
  logic [2:0]    reg_addr = 3'd0;
  logic [31:0]   reg_wdata = 32'd0;
  logic          reg_wvalid = 1'b0;
  logic [31:0]   reg_rdata;

  int checks = 0;
  int errors = 0;

  sample_dma #(.AW(AW)) dut (
    .clk_48(clk_48), .irst(irst),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd(fifo_rd),
    .dma_req(dma_req), .dma_gnt(dma_gnt),
    .awaddr(awaddr), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wvalid(reg_wvalid),
    .reg_rdata(reg_rdata)
  );

  always #5 clk_48 = ~clk_48;

  // Standard-mode FIFO: data appears the cycle after the pop strobe.
  logic [15:0] fifo_mem [0:255];
  int wr_n = 0, rd_n = 0, pop_n = 0, bad_pop = 0;
  logic fifo_flush = 1'b0;
  assign fifo_empty = (rd_n == wr_n);

  always @(posedge clk_48) begin
    if (fifo_flush) begin
      rd_n <= wr_n;
    end else if (fifo_rd) begin
      if (rd_n == wr_n) begin
        bad_pop <= bad_pop + 1;
      end else begin
        fifo_rd_data <= fifo_mem[rd_n];
        rd_n <= rd_n + 1;
      end
      pop_n <= pop_n + 1;
    end
  end

  // SDRAM side: log every accepted write.
  logic [AW-1:0] log_addr [0:255];
  logic [15:0]   log_data [0:255];
  int log_n = 0;
  always @(posedge clk_48) begin
    if (wvalid && wready && log_n < 256) begin
      log_addr[log_n] <= awaddr;
      log_data[log_n] <= wdata;
      log_n <= log_n + 1;
    end
  end

  // Grant/ready: 0 = always ready, 1 = random, 2 = manual.
  int   hs_mode = 0;
  logic gnt_man = 1'b0, wready_man = 1'b0;
  always @(posedge clk_48) begin
    #2;
    case (hs_mode)
      0: begin dma_gnt = 1'b1; wready = 1'b1; end
      1: begin dma_gnt = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1)); end
      default: begin dma_gnt = gnt_man; wready = wready_man; end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk_48);
    reg_addr = a; reg_wdata = d; reg_wvalid = 1'b1;
    @(negedge clk_48);
    reg_wvalid = 1'b0;
    $display("reg write [%0d] = 0x%08h", a, d);
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk_48);
    reg_addr = a;
    #1 d = reg_rdata;
  endtask

  task automatic flush_and_push(input int n, output int first);
    @(negedge clk_48); fifo_flush = 1'b1;
    @(negedge clk_48); fifo_flush = 1'b0;
    first = wr_n;
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_n] = 16'($urandom);
      wr_n++;
    end
  endtask

  // Reference model: the window walks base, base+1, ... modulo 2^AW; wrap restarts at
  // base when LIMIT is reached, no-wrap stops there with full set.
  task automatic run_case(input string tag, input logic [AW-1:0] base, input int len,
                          input bit wrap, input int nwords, input int mode);
    int d0, log0, pop0, exp_n, cyc;
    logic [AW-1:0] lim, a;
    logic [31:0] r;
    bit exp_full;
    hs_mode = mode;
    reg_write(3'd0, 32'd0);
    flush_and_push(nwords, d0);
    lim = base + AW'(len);
    reg_write(3'd1, 32'(base));
    reg_write(3'd2, 32'(lim));
    log0 = log_n; pop0 = pop_n;
    exp_n = wrap ? nwords : ((nwords < len) ? nwords : len);
    exp_full = !wrap && (nwords >= len);
    reg_write(3'd0, {30'b0, wrap, 1'b1});
    cyc = 0;
    while ((log_n - log0) < exp_n && cyc < 2000) begin
      @(negedge clk_48);
      cyc++;
    end
    check({tag, " timeout"}, 64'(cyc < 2000), 64'd1);
    repeat (20) @(negedge clk_48);
    check({tag, " nwrites"}, 64'(log_n - log0), 64'(exp_n));
    for (int i = 0; i < exp_n && i < (log_n - log0); i++) begin
      a = wrap ? base + AW'(i % len) : base + AW'(i);
      $display("%s write %0d: addr 0x%06h data 0x%04h", tag, i, log_addr[log0 + i], log_data[log0 + i]);
      check({tag, " addr"}, 64'(log_addr[log0 + i]), 64'(a));
      check({tag, " data"}, 64'(log_data[log0 + i]), 64'(fifo_mem[d0 + i]));
    end
    check({tag, " pops"}, 64'(pop_n - pop0), 64'(exp_n));
    reg_read(3'd4, r);
    check({tag, " COUNT"}, 64'(r), 64'(exp_n));
    reg_read(3'd3, r);
    a = wrap ? base + AW'(nwords % len) : base + AW'(exp_n);
    check({tag, " WPTR"}, 64'(r), 64'(a));
    reg_read(3'd0, r);
    check({tag, " CTRL"}, 64'(r), 64'({exp_full, wrap, 1'b1}));
  endtask

  initial begin
    logic [31:0] r;
    logic [AW-1:0] ad;
    logic [15:0] dt;
    int d0, log0, pop0, cyc;

    repeat (3) @(negedge clk_48);
    #1;
    check("rst fifo_rd", 64'(fifo_rd), 64'd0);
    check("rst dma_req", 64'(dma_req), 64'd0);
    check("rst wvalid", 64'(wvalid), 64'd0);
    check("rst awaddr", 64'(awaddr), 64'd0);
    check("rst wdata", 64'(wdata), 64'd0);
    irst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      reg_read(3'(i), r);
      check("rst reg", 64'(r), 64'd0);
    end
    // Words available but no enable: nothing may be popped.
    flush_and_push(2, d0);
    repeat (10) @(negedge clk_48);
    check("no pop before en", 64'(pop_n), 64'd0);
    reg_write(3'd6, 32'hFFFF_FFFF);
    reg_read(3'd6, r);
    check("reg6 reads 0", 64'(r), 64'd0);

    // One-shot fill then wrap-around, always granted.
    run_case("A", 24'h000100, 4, 1'b0, 5, 0);
    check("A fifo left", 64'(wr_n - rd_n), 64'd1);
    run_case("B", 24'h000100, 4, 1'b1, 6, 0);
    run_case("WRAP_TOP", 24'hFFFFFE, 4, 1'b1, 7, 1);
    for (int k = 0; k < 4; k++) begin
      run_case("RND", 24'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)),
               $urandom_range(1, 8), 1);
    end

    // Grant withheld, then slow wready: address/data must not move.
    hs_mode = 2; gnt_man = 1'b0; wready_man = 1'b0;
    reg_write(3'd0, 32'd0);
    flush_and_push(1, d0);
    reg_write(3'd1, 32'h300);
    reg_write(3'd2, 32'h310);
    log0 = log_n; pop0 = pop_n;
    reg_write(3'd0, 32'd1);
    cyc = 0;
    while (!dma_req && cyc < 50) begin @(negedge clk_48); cyc++; end
    check("C req", 64'(dma_req), 64'd1);
    repeat (10) @(negedge clk_48);
    check("C no gnt wvalid", 64'(wvalid), 64'd0);
    check("C no gnt req", 64'(dma_req), 64'd1);
    gnt_man = 1'b1;
    cyc = 0;
    while (!wvalid && cyc < 20) begin @(negedge clk_48); cyc++; end
    check("C wvalid", 64'(wvalid), 64'd1);
    ad = awaddr; dt = wdata;
    check("C awaddr", 64'(ad), 64'h300);
    check("C wdata", 64'(dt), 64'(fifo_mem[d0]));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_48);
      check("C hold wvalid", 64'(wvalid), 64'd1);
      check("C hold awaddr", 64'(awaddr), 64'(ad));
      check("C hold wdata", 64'(wdata), 64'(dt));
    end
    wready_man = 1'b1;
    @(negedge clk_48);
    wready_man = 1'b0;
    repeat (10) @(negedge clk_48);
    check("C one write", 64'(log_n - log0), 64'd1);
    check("C wvalid after", 64'(wvalid), 64'd0);
    $display("C write: addr 0x%06h data 0x%04h", ad, dt);

    // Disable right after a pop: that word still lands, nothing further.
    hs_mode = 0;
    reg_write(3'd0, 32'd0);
    flush_and_push(3, d0);
    reg_write(3'd1, 32'h400);
    reg_write(3'd2, 32'h410);
    log0 = log_n; pop0 = pop_n;
    reg_write(3'd0, 32'd1);
    cyc = 0;
    while (!fifo_rd && cyc < 20) begin @(negedge clk_48); cyc++; end
    check("D saw pop", 64'(fifo_rd), 64'd1);
    reg_addr = 3'd0; reg_wdata = 32'd0; reg_wvalid = 1'b1;
    @(negedge clk_48);
    reg_wvalid = 1'b0;
    repeat (30) @(negedge clk_48);
    check("D writes", 64'(log_n - log0), 64'd1);
    check("D pops", 64'(pop_n - pop0), 64'd1);
    check("D addr", 64'(log_addr[log0]), 64'h400);
    check("D data", 64'(log_data[log0]), 64'(fifo_mem[d0]));
    reg_read(3'd0, r);
    check("D CTRL", 64'(r), 64'd0);

    // Reset during WRITE.
    hs_mode = 2; gnt_man = 1'b1; wready_man = 1'b0;
    reg_write(3'd0, 32'd0);
    flush_and_push(2, d0);
    reg_write(3'd1, 32'h500);
    reg_write(3'd2, 32'h510);
    log0 = log_n; pop0 = pop_n;
    reg_write(3'd0, 32'd1);
    cyc = 0;
    while (!wvalid && cyc < 30) begin @(negedge clk_48); cyc++; end
    check("E in write", 64'(wvalid), 64'd1);
    irst = 1'b1;
    #1;
    check("E wvalid", 64'(wvalid), 64'd0);
    check("E dma_req", 64'(dma_req), 64'd0);
    check("E awaddr", 64'(awaddr), 64'd0);
    check("E wdata", 64'(wdata), 64'd0);
    for (int i = 0; i < 5; i++) begin
      reg_read(3'(i), r);
      check("E reg", 64'(r), 64'd0);
    end
    @(negedge clk_48);
    irst = 1'b0;
    wready_man = 1'b1;
    repeat (10) @(negedge clk_48);
    check("E no pop", 64'(pop_n - pop0), 64'd1);
    check("E no write", 64'(log_n - log0), 64'd0);
    reg_write(3'd1, 32'h600);
    reg_write(3'd2, 32'h610);
    reg_write(3'd0, 32'd1);
    cyc = 0;
    while (log_n == log0 && cyc < 50) begin @(negedge clk_48); cyc++; end
    check("E rewrite", 64'(log_n - log0), 64'd1);
    check("E addr", 64'(log_addr[log0]), 64'h600);
    check("E data", 64'(log_data[log0]), 64'(fifo_mem[d0 + 1]));

    // Empty window: full at once, never pops; clearing full lets it re-set.
    hs_mode = 0;
    reg_write(3'd0, 32'd0);
    flush_and_push(2, d0);
    reg_write(3'd1, 32'h200);
    reg_write(3'd2, 32'h200);
    pop0 = pop_n;
    reg_write(3'd0, 32'd1);
    #1;
    check("F full at once", 64'(reg_rdata), 64'd5);
    repeat (10) @(negedge clk_48);
    check("F no pop", 64'(pop_n - pop0), 64'd0);
    reg_write(3'd0, 32'd5);
    #1;
    check("F cleared", 64'(reg_rdata[2]), 64'd0);
    repeat (3) @(negedge clk_48);
    reg_read(3'd0, r);
    check("F full reset", 64'(r), 64'd5);
    check("F no pop 2", 64'(pop_n - pop0), 64'd0);

    check("pop while empty", 64'(bad_pop), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
